// File: rtl/invader_formation.sv
// Enemy formation engine: ROWS x COLS alive mask, left/right march with edge drops,
// shot collision with single kill per cycle, and a registered pixel/colour layer.
`timescale 1ns/1ps
module invader_formation #(
    parameter int unsigned  COLS    = 8,
    parameter int unsigned  ROWS    = 3,
    parameter int unsigned  X0      = 180,
    parameter int unsigned  Y0      = 40,
    parameter int unsigned  DX      = 80,
    parameter int unsigned  DY      = 50,
    parameter int unsigned  W       = 32,
    parameter int unsigned  H       = 24,
    parameter int unsigned  STEP_X  = 4,
    parameter int unsigned  STEP_Y  = 16,
    parameter int unsigned  X_MIN   = 0,
    parameter int unsigned  X_MAX   = 639,
    parameter int unsigned  Y_FLOOR = 440,
    parameter int unsigned  MIN_DIV = 2,
    parameter logic [23:0]  COLOR   = 24'hFF00FF,
    localparam int unsigned N       = ROWS * COLS,
    localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned CNT_W   = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             frame_tick,
    input  logic [9:0]       h_counter,
    input  logic [9:0]       v_counter,
    input  logic             shot_valid,
    input  logic [9:0]       shot_x,
    input  logic [9:0]       shot_y,
    output logic             hit,
    output logic [IDX_W-1:0] hit_index,
    output logic [CNT_W-1:0] alive_count,
    output logic [9:0]       formation_x,
    output logic [9:0]       formation_y,
    output logic             all_dead,
    output logic             reached_floor,
    output logic             pix_on,
    output logic [7:0]       R,
    output logic [7:0]       G,
    output logic [7:0]       B
);

    localparam int unsigned FC_W = $clog2(MIN_DIV + N + 1);

    typedef enum logic [1:0] {StMarchR, StMarchL, StHalt} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     mask_q, mask_d;
    logic [9:0]       fx_q, fx_d, fy_q, fy_d;
    logic [CNT_W-1:0] alive_q, alive_d;
    logic [FC_W-1:0]  cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic             floor_q, floor_d;
    logic             pix_q, pix_d;
    logic [23:0]      rgb_q, rgb_d;

    logic [10:0]      col_x0 [COLS];
    logic [10:0]      row_y0 [ROWS];
    logic [COLS-1:0]  shot_col, pix_col, col_alive;
    logic [ROWS-1:0]  shot_row, pix_row, row_alive;
    logic [N-1:0]     shot_match;
    logic             kill_found, pix_hit;
    logic [IDX_W-1:0] kill_idx;
    int               lc, rc, lr;
    logic [10:0]      right_x, bottom_y;
    logic             at_right, at_left, floor_hit, march_evt;
    logic [FC_W-1:0]  period_m1;

    // True when p lies in [lo, lo+len-1]; widened so the upper bound cannot wrap.
    function automatic logic in_span(input logic [9:0] p, input logic [10:0] lo,
                                     input logic [10:0] len);
        logic [11:0] hi;
        hi = {1'b0, lo} + {1'b0, len};
        return ({2'b00, p} >= {1'b0, lo}) && ({2'b00, p} < hi);
    endfunction

    // Per-column x origin and per-row y origin of the current formation.
    always_comb begin
        for (int c = 0; c < int'(COLS); c++) col_x0[c] = {1'b0, fx_q} + 11'(c * int'(DX));
        for (int r = 0; r < int'(ROWS); r++) row_y0[r] = {1'b0, fy_q} + 11'(r * int'(DY));
    end

    // Column/row membership of the shot point and the current pixel.
    always_comb begin
        for (int c = 0; c < int'(COLS); c++) begin
            shot_col[c] = in_span(shot_x, col_x0[c], 11'(W));
            pix_col[c]  = in_span(h_counter, col_x0[c], 11'(W));
        end
        for (int r = 0; r < int'(ROWS); r++) begin
            shot_row[r] = in_span(shot_y, row_y0[r], 11'(H));
            pix_row[r]  = in_span(v_counter, row_y0[r], 11'(H));
        end
    end

    // Alive-rectangle matching; the lowest matching index wins the kill.
    always_comb begin
        shot_match = '0;
        pix_hit    = 1'b0;
        kill_found = 1'b0;
        kill_idx   = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                shot_match[r*int'(COLS)+c] = mask_q[r*int'(COLS)+c] & shot_row[r] & shot_col[c];
                pix_hit = pix_hit | (mask_q[r*int'(COLS)+c] & pix_row[r] & pix_col[c]);
            end
        end
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (shot_match[i]) begin
                kill_found = 1'b1;
                kill_idx   = IDX_W'(i);
            end
        end
    end

    // Extents of the surviving formation (pre-kill mask) for edge and floor tests.
    always_comb begin
        col_alive = '0;
        row_alive = '0;
        lc = 0;
        rc = 0;
        lr = 0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (mask_q[r*int'(COLS)+c]) begin
                    col_alive[c] = 1'b1;
                    row_alive[r] = 1'b1;
                end
            end
        end
        for (int c = int'(COLS) - 1; c >= 0; c--) if (col_alive[c]) lc = c;
        for (int c = 0; c < int'(COLS); c++) if (col_alive[c]) rc = c;
        for (int r = 0; r < int'(ROWS); r++) if (row_alive[r]) lr = r;
    end

    // Edge, floor and march-timing decisions.
    always_comb begin
        right_x   = col_x0[rc] + 11'(W - 1) + 11'(STEP_X);
        at_right  = right_x > 11'(X_MAX);
        at_left   = col_x0[lc] < 11'(X_MIN + STEP_X);
        bottom_y  = row_y0[lr] + 11'(H - 1);
        floor_hit = (|mask_q) && (bottom_y >= 11'(Y_FLOOR));
        // Fewer survivors -> shorter period -> faster march.
        period_m1 = FC_W'(MIN_DIV) + FC_W'(alive_q) - FC_W'(1);
        march_evt = frame_tick && (cnt_q >= period_m1);
    end

    // Next-state logic: restart first, then kill, floor/all-dead halt, march.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        fx_d      = fx_q;
        fy_d      = fy_q;
        alive_d   = alive_q;
        cnt_d     = cnt_q;
        hit_d     = 1'b0;
        hit_idx_d = hit_idx_q;
        floor_d   = floor_q;
        pix_d     = pix_hit;
        if (restart) begin
            state_d   = StMarchR;
            mask_d    = '1;
            fx_d      = 10'(X0);
            fy_d      = 10'(Y0);
            alive_d   = CNT_W'(N);
            cnt_d     = '0;
            hit_idx_d = '0;
            floor_d   = 1'b0;
            pix_d     = 1'b0;
        end else if (state_q != StHalt) begin
            if (shot_valid && kill_found) begin
                mask_d[kill_idx] = 1'b0;
                alive_d          = alive_q - CNT_W'(1);
                hit_d            = 1'b1;
                hit_idx_d        = kill_idx;
            end
            if (floor_hit) begin
                floor_d = 1'b1;
                state_d = StHalt;
            end else if (all_dead) begin
                state_d = StHalt;
            end else if (frame_tick) begin
                if (march_evt) begin
                    cnt_d = '0;
                    if (state_q == StMarchR) begin
                        if (at_right) begin
                            fy_d    = fy_q + 10'(STEP_Y);
                            state_d = StMarchL;
                        end else begin
                            fx_d = fx_q + 10'(STEP_X);
                        end
                    end else begin
                        if (at_left) begin
                            fy_d    = fy_q + 10'(STEP_Y);
                            state_d = StMarchR;
                        end else begin
                            fx_d = fx_q - 10'(STEP_X);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + FC_W'(1);
                end
            end
        end
        rgb_d = pix_d ? COLOR : 24'h000000;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StMarchR;
            mask_q    <= '1;
            fx_q      <= 10'(X0);
            fy_q      <= 10'(Y0);
            alive_q   <= CNT_W'(N);
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            floor_q   <= 1'b0;
            pix_q     <= 1'b0;
            rgb_q     <= 24'h000000;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            fx_q      <= fx_d;
            fy_q      <= fy_d;
            alive_q   <= alive_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            floor_q   <= floor_d;
            pix_q     <= pix_d;
            rgb_q     <= rgb_d;
        end
    end

    // Output mapping.
    always_comb begin
        hit           = hit_q;
        hit_index     = hit_idx_q;
        alive_count   = alive_q;
        formation_x   = fx_q;
        formation_y   = fy_q;
        all_dead      = (alive_q == '0);
        reached_floor = floor_q;
        pix_on        = pix_q;
        R             = rgb_q[23:16];
        G             = rgb_q[15:8];
        B             = rgb_q[7:0];
    end

endmodule

// File: tb/tb_invader_formation.sv
// Directed self-checking bench for invader_formation (default parameters).
`timescale 1ns/1ps
module tb_invader_formation;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] h_counter = '0;
    logic [9:0] v_counter = '0;
    logic       shot_valid = 1'b0;
    logic [9:0] shot_x = '0;
    logic [9:0] shot_y = '0;
    logic       hit;
    logic [4:0] hit_index;
    logic [4:0] alive_count;
    logic [9:0] formation_x;
    logic [9:0] formation_y;
    logic       all_dead;
    logic       reached_floor;
    logic       pix_on;
    logic [7:0] R, G, B;

    int total = 0;
    int passed = 0;

    invader_formation dut (
        .clk(clk), .reset(reset), .restart(restart), .frame_tick(frame_tick),
        .h_counter(h_counter), .v_counter(v_counter), .shot_valid(shot_valid),
        .shot_x(shot_x), .shot_y(shot_y), .hit(hit), .hit_index(hit_index),
        .alive_count(alive_count), .formation_x(formation_x), .formation_y(formation_y),
        .all_dead(all_dead), .reached_floor(reached_floor), .pix_on(pix_on),
        .R(R), .G(G), .B(B)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    // One-cycle shot; returns the registered hit outputs seen after the edge.
    task automatic shoot(input int x, input int y, output logic got_hit,
                         output logic [4:0] got_idx);
        shot_x = 10'(x);
        shot_y = 10'(y);
        shot_valid = 1'b1;
        step();
        shot_valid = 1'b0;
        got_hit = hit;
        got_idx = hit_index;
    endtask

    // Kill every enemy except the listed survivors (a, b); -1 keeps none.
    task automatic kill_except(input int a, input int b, output int hits,
                               output logic [4:0] last_idx);
        logic h;
        logic [4:0] idx;
        hits = 0;
        last_idx = '0;
        for (int i = 0; i < 24; i++) begin
            if (i != a && i != b) begin
                shoot(181 + 80 * (i % 8), 41 + 50 * (i / 8), h, idx);
                if (h) begin
                    hits++;
                    last_idx = idx;
                end
            end
        end
    endtask

    task automatic test_reset();
        h_counter = 10'd181;
        v_counter = 10'd41;
        repeat (3) step();
        total++; if (hit !== 1'b0) $display("FAIL reset_hit: got %0d want 0", hit); else passed++;
        total++; if (hit_index !== 5'd0) $display("FAIL reset_hit_index: got %0d want 0", hit_index); else passed++;
        total++; if (alive_count !== 5'd24) $display("FAIL reset_alive: got %0d want 24", alive_count); else passed++;
        total++; if (formation_x !== 10'd180) $display("FAIL reset_fx: got %0d want 180", formation_x); else passed++;
        total++; if (formation_y !== 10'd40) $display("FAIL reset_fy: got %0d want 40", formation_y); else passed++;
        total++; if (all_dead !== 1'b0) $display("FAIL reset_all_dead: got %0d want 0", all_dead); else passed++;
        total++; if (reached_floor !== 1'b0) $display("FAIL reset_floor: got %0d want 0", reached_floor); else passed++;
        total++; if (pix_on !== 1'b0) $display("FAIL reset_pix: got %0d want 0", pix_on); else passed++;
        total++; if ({R, G, B} !== 24'h0) $display("FAIL reset_rgb: got %h want 000000", {R, G, B}); else passed++;
        reset = 1'b0;
        step();
        // Enemy 0 covers x 180..211, y 40..63.
        total++; if (pix_on !== 1'b1) $display("FAIL pix_enemy0: got %0d want 1", pix_on); else passed++;
        total++; if ({R, G, B} !== 24'hFF00FF) $display("FAIL rgb_enemy0: got %h want ff00ff", {R, G, B}); else passed++;
    endtask

    task automatic test_march();
        // Full formation: period 26. Right edge at 180+560+31+4=775 > 639 -> drop and turn.
        pulse_ticks(25);
        total++; if (formation_x !== 10'd180) $display("FAIL march_pre_fx: got %0d want 180", formation_x); else passed++;
        total++; if (formation_y !== 10'd40) $display("FAIL march_pre_fy: got %0d want 40", formation_y); else passed++;
        pulse_ticks(1);
        total++; if (formation_x !== 10'd180) $display("FAIL march_ev1_fx: got %0d want 180", formation_x); else passed++;
        total++; if (formation_y !== 10'd56) $display("FAIL march_ev1_fy: got %0d want 56", formation_y); else passed++;
        // Now marching left: 180 is not < 4, so it moves left.
        pulse_ticks(26);
        total++; if (formation_x !== 10'd176) $display("FAIL march_ev2_fx: got %0d want 176", formation_x); else passed++;
        total++; if (formation_y !== 10'd56) $display("FAIL march_ev2_fy: got %0d want 56", formation_y); else passed++;
    endtask

    task automatic test_shot();
        logic h;
        logic [4:0] idx;
        // Restart wins over a simultaneous shot and frame tick.
        restart = 1'b1;
        frame_tick = 1'b1;
        shot_x = 10'd181;
        shot_y = 10'd41;
        shot_valid = 1'b1;
        step();
        restart = 1'b0;
        frame_tick = 1'b0;
        shot_valid = 1'b0;
        total++; if (hit !== 1'b0) $display("FAIL restart_prio_hit: got %0d want 0", hit); else passed++;
        total++; if (alive_count !== 5'd24) $display("FAIL restart_prio_alive: got %0d want 24", alive_count); else passed++;
        total++; if (formation_x !== 10'd180 || formation_y !== 10'd40)
            $display("FAIL restart_prio_pos: got %0d,%0d want 180,40", formation_x, formation_y); else passed++;
        // Gap between column 0 (ends 211) and column 1 (starts 260).
        shoot(215, 41, h, idx);
        total++; if (h !== 1'b0) $display("FAIL shot_gap_hit: got %0d want 0", h); else passed++;
        shoot(181, 41, h, idx);
        total++; if (h !== 1'b1) $display("FAIL shot0_hit: got %0d want 1", h); else passed++;
        total++; if (idx !== 5'd0) $display("FAIL shot0_index: got %0d want 0", idx); else passed++;
        total++; if (alive_count !== 5'd23) $display("FAIL shot0_alive: got %0d want 23", alive_count); else passed++;
        step();
        total++; if (hit !== 1'b0) $display("FAIL shot0_pulse: got %0d want 0", hit); else passed++;
        h_counter = 10'd181;
        v_counter = 10'd41;
        step();
        total++; if (pix_on !== 1'b0) $display("FAIL dead_pix: got %0d want 0", pix_on); else passed++;
        total++; if ({R, G, B} !== 24'h0) $display("FAIL dead_rgb: got %h want 000000", {R, G, B}); else passed++;
        h_counter = 10'd291;
        v_counter = 10'd63;
        step();
        total++; if (pix_on !== 1'b1) $display("FAIL pix_corner: got %0d want 1", pix_on); else passed++;
        h_counter = 10'd292;
        step();
        total++; if (pix_on !== 1'b0) $display("FAIL pix_past_edge: got %0d want 0", pix_on); else passed++;
        // Held shot: one kill, then nothing left under the point.
        shot_x = 10'd261;
        shot_y = 10'd41;
        shot_valid = 1'b1;
        step();
        total++; if (hit !== 1'b1 || hit_index !== 5'd1)
            $display("FAIL held_first: got %0d/%0d want 1/1", hit, hit_index); else passed++;
        step();
        shot_valid = 1'b0;
        total++; if (hit !== 1'b0) $display("FAIL held_second: got %0d want 0", hit); else passed++;
        total++; if (alive_count !== 5'd22) $display("FAIL held_alive: got %0d want 22", alive_count); else passed++;
    endtask

    task automatic test_edge_turn();
        int hits;
        logic [4:0] last;
        do_restart();
        // Survivors: (0,0) and (0,6). lc=0, rc=6; period 4.
        kill_except(0, 6, hits, last);
        total++; if (hits != 22) $display("FAIL edge_kills: got %0d want 22", hits); else passed++;
        total++; if (last !== 5'd23) $display("FAIL edge_last_index: got %0d want 23", last); else passed++;
        total++; if (alive_count !== 5'd2) $display("FAIL edge_alive: got %0d want 2", alive_count); else passed++;
        pulse_ticks(4);
        total++; if (formation_x !== 10'd180 || formation_y !== 10'd56)
            $display("FAIL edge_first: got %0d,%0d want 180,56", formation_x, formation_y); else passed++;
        pulse_ticks(4 * 45);
        total++; if (formation_x !== 10'd0 || formation_y !== 10'd56)
            $display("FAIL edge_left_end: got %0d,%0d want 0,56", formation_x, formation_y); else passed++;
        pulse_ticks(4);
        total++; if (formation_x !== 10'd0 || formation_y !== 10'd72)
            $display("FAIL edge_left_turn: got %0d,%0d want 0,72", formation_x, formation_y); else passed++;
        // fx=124: 124+480+31+4 = 639, not beyond X_MAX, so it still moves.
        pulse_ticks(4 * 31);
        total++; if (formation_x !== 10'd124 || formation_y !== 10'd72)
            $display("FAIL edge_at_124: got %0d,%0d want 124,72", formation_x, formation_y); else passed++;
        pulse_ticks(4);
        total++; if (formation_x !== 10'd128 || formation_y !== 10'd72)
            $display("FAIL edge_to_128: got %0d,%0d want 128,72", formation_x, formation_y); else passed++;
        pulse_ticks(4);
        total++; if (formation_x !== 10'd128 || formation_y !== 10'd88)
            $display("FAIL edge_right_turn: got %0d,%0d want 128,88", formation_x, formation_y); else passed++;
        pulse_ticks(4);
        total++; if (formation_x !== 10'd124 || formation_y !== 10'd88)
            $display("FAIL edge_flip_left: got %0d,%0d want 124,88", formation_x, formation_y); else passed++;
    endtask

    task automatic test_kill_all();
        int hits;
        logic [4:0] last;
        do_restart();
        kill_except(-1, -1, hits, last);
        total++; if (hits != 24) $display("FAIL killall_hits: got %0d want 24", hits); else passed++;
        total++; if (last !== 5'd23) $display("FAIL killall_last: got %0d want 23", last); else passed++;
        total++; if (alive_count !== 5'd0) $display("FAIL killall_alive: got %0d want 0", alive_count); else passed++;
        total++; if (all_dead !== 1'b1) $display("FAIL killall_flag: got %0d want 1", all_dead); else passed++;
        pulse_ticks(30);
        total++; if (formation_x !== 10'd180 || formation_y !== 10'd40)
            $display("FAIL killall_frozen: got %0d,%0d want 180,40", formation_x, formation_y); else passed++;
    endtask

    task automatic test_floor();
        int hits;
        int n;
        logic [4:0] last;
        logic h;
        logic [4:0] idx;
        do_restart();
        // Survivors (2,0) and (2,7): oscillate between fx 0 and 48, drop 16 per turn.
        // 18 drops reach fy=328 (328+100+23 = 451 >= 440) at event 255 = tick 1020.
        kill_except(16, 23, hits, last);
        n = 0;
        while (reached_floor !== 1'b1 && n < 2000) begin
            pulse_ticks(1);
            n++;
        end
        total++; if (n != 1020) $display("FAIL floor_ticks: got %0d want 1020", n); else passed++;
        total++; if (formation_x !== 10'd0 || formation_y !== 10'd328)
            $display("FAIL floor_pos: got %0d,%0d want 0,328", formation_x, formation_y); else passed++;
        pulse_ticks(20);
        total++; if (reached_floor !== 1'b1) $display("FAIL floor_sticky: got %0d want 1", reached_floor); else passed++;
        total++; if (formation_x !== 10'd0 || formation_y !== 10'd328)
            $display("FAIL floor_halt_pos: got %0d,%0d want 0,328", formation_x, formation_y); else passed++;
        // Live enemy (2,0) spans x 0..31, y 428..451, but HALT ignores shots.
        shoot(1, 429, h, idx);
        total++; if (h !== 1'b0) $display("FAIL halt_shot_hit: got %0d want 0", h); else passed++;
        total++; if (alive_count !== 5'd2) $display("FAIL halt_shot_alive: got %0d want 2", alive_count); else passed++;
        do_restart();
        total++; if (formation_x !== 10'd180 || formation_y !== 10'd40)
            $display("FAIL restart_pos: got %0d,%0d want 180,40", formation_x, formation_y); else passed++;
        total++; if (alive_count !== 5'd24) $display("FAIL restart_alive: got %0d want 24", alive_count); else passed++;
        total++; if (reached_floor !== 1'b0) $display("FAIL restart_floor: got %0d want 0", reached_floor); else passed++;
    endtask

    task automatic test_async_reset();
        do_restart();
        pulse_ticks(26);
        h_counter = 10'd261;
        v_counter = 10'd57;
        shot_x = 10'd181;
        shot_y = 10'd57;
        shot_valid = 1'b1;
        step();
        shot_valid = 1'b0;
        total++; if (hit !== 1'b1 || pix_on !== 1'b1)
            $display("FAIL areset_pre: got hit %0d pix %0d want 1 1", hit, pix_on); else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++; if (hit !== 1'b0) $display("FAIL areset_hit: got %0d want 0", hit); else passed++;
        total++; if (alive_count !== 5'd24) $display("FAIL areset_alive: got %0d want 24", alive_count); else passed++;
        total++; if (formation_y !== 10'd40) $display("FAIL areset_fy: got %0d want 40", formation_y); else passed++;
        total++; if (pix_on !== 1'b0 || {R, G, B} !== 24'h0)
            $display("FAIL areset_pix: got %0d %h want 0 000000", pix_on, {R, G, B}); else passed++;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_march();
        test_shot();
        test_edge_turn();
        test_kill_all();
        test_floor();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
